mem_access_ctrl: RTL

//  Initiator side of the data-memory interface, in the MEM stage between the EX/MEM and MEM/WB registers.
//  - Takes one load/store request per instruction and drives mem_r_en/mem_w_en/mem_addr/mem_wdata
//    to the byte-addressed, big-endian data memory.
//  - Emulates a multi-cycle memory: holds the pipeline with freeze until the access completes.
//  - Flags misaligned or out-of-window addresses instead of issuing them.

---
 rtl/mem_access_ctrl_pkg.sv | 14 +
 rtl/mem_wait_counter.sv | 16 +
 rtl/mem_access_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: FSM encoding, memory window defaults and the request check shared with the data memory.
package mem_access_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam int unsigned MEM_BASE_DEF = 1024;
  localparam int unsigned MEM_BYTES_DEF = 256;
  localparam int CHK_W = 33;
  // 33-bit compare keeps addresses near 2^32 from wrapping into the window
  function automatic logic req_err(input logic r, input logic w, input logic [31:0] addr,
                                   input logic [CHK_W-1:0] base, input logic [CHK_W-1:0] bytes);
    logic [CHK_W-1:0] a;
    a = {1'b0, addr};
    return (r & w) | (addr[1:0] != 2'b00) | (a < base) | (a > base + bytes - CHK_W'(4));
  endfunction
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable 4-bit down-counter with a zero flag.
module mem_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && !zero) cnt <= cnt - 4'd1;
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator that stalls the pipeline over a multi-cycle memory access.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned MEM_BASE    = MEM_BASE_DEF,
  parameter int unsigned MEM_BYTES   = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_r_en,
  input  logic        req_w_en,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        freeze,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  state_t      state;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_w, valid, err, accept, zero;
  assign valid  = req_r_en | req_w_en;
  assign err    = req_err(req_r_en, req_w_en, req_addr, CHK_W'(MEM_BASE), CHK_W'(MEM_BYTES));
  assign accept = state == IDLE && valid && !err;
  assign freeze = accept || state == ACCESS;
  // write strobe only on the last wait state so each store lands exactly once
  assign mem_r_en  = state == ACCESS && !lat_w;
  assign mem_w_en  = state == ACCESS && lat_w && zero;
  assign mem_addr  = state == ACCESS ? lat_addr : '0;
  assign mem_wdata = state == ACCESS ? lat_wdata : '0;
  mem_wait_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       (state == ACCESS),
    .load_val (4'(WAIT_STATES - 1)),
    .zero     (zero)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_w       <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_w     <= req_w_en;
            state     <= ACCESS;
          end else addr_err <= valid;
        ACCESS:
          if (zero) begin
            state <= DONE;
            if (!lat_w) begin
              rdata       <= mem_rdata;
              rdata_valid <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule
